jk_excite_seq: RTL and testbench



---
 rtl/jk_excite_seq.sv | 109 ++++++++++
 tb/tb_jk_excite_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excite_seq.sv
// jk_excite_seq: turns (Q, target) into J/K excitation for a JK flip-flop
// bank, then checks the bank's Q on the following cycle.
module jk_excite_seq #(
   parameter int WIDTH      = 4,
   parameter bit USE_TOGGLE = 1'b0
) (
   input  logic             CLK,
   input  logic             RST_not,
   input  logic [WIDTH-1:0] T_DATA,
   input  logic             T_VALID,
   output logic             T_READY,
   output logic [WIDTH-1:0] J,
   output logic [WIDTH-1:0] K,
   input  logic [WIDTH-1:0] Q,
   output logic             DONE,
   output logic             MISMATCH,
   output logic [WIDTH-1:0] MISMATCH_MASK,
   output logic [7:0]       ERR_COUNT,
   input  logic             CLR_ERR
);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic [WIDTH-1:0] j_q, j_d;
   logic [WIDTH-1:0] k_q, k_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic             done_q, done_d;
   logic             mism_q, mism_d;
   logic [7:0]       err_q, err_d;

   logic [WIDTH-1:0] diff, rise, fall, chk_mask;

   assign diff     = Q ^ T_DATA;
   assign rise     = ~Q & T_DATA;
   assign fall     = Q & ~T_DATA;
   assign chk_mask = Q ^ tgt_q;

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      j_d     = '0;
      k_d     = '0;
      mask_d  = mask_q;
      done_d  = 1'b0;
      mism_d  = 1'b0;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (T_VALID) begin
               tgt_d = T_DATA;
               if (USE_TOGGLE) begin
                  j_d = diff;
                  k_d = diff;
               end else begin
                  j_d = rise;
                  k_d = fall;
               end
               state_d = DRIVE;
            end
         end
         DRIVE: state_d = CHECK;
         CHECK: begin
            mask_d = chk_mask;
            done_d = 1'b1;
            mism_d = |chk_mask;
            if (mism_d && err_q != 8'hFF)
               err_d = err_q + 8'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // clear has priority over a same-edge increment
      if (CLR_ERR)
         err_d = '0;
   end

   always_ff @(posedge CLK or negedge RST_not) begin
      if (!RST_not) begin
         state_q <= IDLE;
         tgt_q   <= '0;
         j_q     <= '0;
         k_q     <= '0;
         mask_q  <= '0;
         done_q  <= 1'b0;
         mism_q  <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         j_q     <= j_d;
         k_q     <= k_d;
         mask_q  <= mask_d;
         done_q  <= done_d;
         mism_q  <= mism_d;
         err_q   <= err_d;
      end
   end

   assign T_READY       = (state_q == IDLE);
   assign J             = j_q;
   assign K             = k_q;
   assign DONE          = done_q;
   assign MISMATCH      = mism_q;
   assign MISMATCH_MASK = mask_q;
   assign ERR_COUNT     = err_q;

endmodule

// File: tb/tb_jk_excite_seq.sv
// Bench for jk_excite_seq: two instances (set/reset and toggle) each
// driving a behavioural JK bank, checked through a result scoreboard.
module tb_jk_excite_seq;

   typedef struct packed {
      logic [3:0] mask;
      logic       mism;
      logic [7:0] err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] t_data;
   logic       v0, v1, clr_err;
   logic       rdy0, rdy1;
   logic [3:0] j0, k0, j1, k1;
   logic [3:0] q0, q1, raw0, raw1;
   logic       done0, done1, mism0, mism1;
   logic [3:0] mask0, mask1;
   logic [7:0] err0, err1;
   logic [3:0] stuck0, ld_val;
   logic       ld1;

   int   total = 0;
   int   bad   = 0;
   int   done0_cnt = 0;
   int   done1_cnt = 0;
   logic [7:0] exp_err0 = '0;
   exp_t sb0[$];
   exp_t sb1[$];

   always #5 clk = ~clk;

   jk_excite_seq #(.WIDTH(4), .USE_TOGGLE(1'b0)) dut0 (
      .CLK(clk), .RST_not(rst_n), .T_DATA(t_data), .T_VALID(v0),
      .T_READY(rdy0), .J(j0), .K(k0), .Q(q0), .DONE(done0),
      .MISMATCH(mism0), .MISMATCH_MASK(mask0), .ERR_COUNT(err0),
      .CLR_ERR(clr_err)
   );

   jk_excite_seq #(.WIDTH(4), .USE_TOGGLE(1'b1)) dut1 (
      .CLK(clk), .RST_not(rst_n), .T_DATA(t_data), .T_VALID(v1),
      .T_READY(rdy1), .J(j1), .K(k1), .Q(q1), .DONE(done1),
      .MISMATCH(mism1), .MISMATCH_MASK(mask1), .ERR_COUNT(err1),
      .CLR_ERR(clr_err)
   );

   // behavioural JK banks; bank 0 output can have bits forced to 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) raw0 <= '0;
      else        raw0 <= (j0 & ~raw0) | (~k0 & raw0);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   raw1 <= '0;
      else if (ld1) raw1 <= ld_val;
      else          raw1 <= (j1 & ~raw1) | (~k1 & raw1);
   end
   assign q0 = raw0 & ~stuck0;
   assign q1 = raw1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic push(input bit which, input logic [3:0] em,
                       input bit emm, input bit clr);
      exp_t e;
      if (which) begin
         e = '{mask: em, mism: emm, err: 8'd0};
         sb1.push_back(e);
      end else begin
         if (clr) exp_err0 = '0;
         else if (emm && exp_err0 != 8'hFF) exp_err0 = exp_err0 + 8'd1;
         e = '{mask: em, mism: emm, err: exp_err0};
         sb0.push_back(e);
      end
   endtask

   task automatic send(input bit which, input logic [3:0] t,
                       input logic [3:0] ej, input logic [3:0] ek,
                       input logic [3:0] em, input bit emm,
                       input bit clr);
      int n = 0;
      @(negedge clk);
      while (!(which ? rdy1 : rdy0)) begin
         @(negedge clk);
         n++;
         if (n > 10) begin
            total++;
            bad++;
            $display("FAIL ready_timeout dut=%0d", which);
            return;
         end
      end
      t_data = t;
      if (which) v1 = 1'b1;
      else       v0 = 1'b1;
      push(which, em, emm, clr);
      @(posedge clk);
      @(negedge clk);
      v0 = 1'b0;
      v1 = 1'b0;
      chk("drive_j", which ? j1 : j0, ej);
      chk("drive_k", which ? k1 : k0, ek);
      @(posedge clk);
      @(negedge clk);
      chk("check_j0", which ? j1 : j0, 4'b0000);
      clr_err = clr;
      @(posedge clk);
      @(negedge clk);
      clr_err = 1'b0;
   endtask

   logic [3:0] bt[3]  = '{4'b0001, 4'b1111, 4'b0000};
   logic [3:0] bj[3]  = '{4'b0001, 4'b1110, 4'b0000};
   logic [3:0] bk[3]  = '{4'b0100, 4'b0000, 4'b1111};
   longint     acc[3];
   int         d0_before;

   initial begin
      fork
         forever begin
            exp_t e;
            @(negedge clk);
            if (done0) begin
               done0_cnt++;
               if (sb0.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL sb0_unexpected_done mask=%b", mask0);
               end else begin
                  e = sb0.pop_front();
                  chk("mask0", mask0, e.mask);
                  chk("mism0", mism0, e.mism);
                  chk("err0", err0, e.err);
               end
            end
            if (done1) begin
               done1_cnt++;
               if (sb1.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL sb1_unexpected_done mask=%b", mask1);
               end else begin
                  e = sb1.pop_front();
                  chk("mask1", mask1, e.mask);
                  chk("mism1", mism1, e.mism);
                  chk("err1", err1, e.err);
               end
            end
         end
      join_none

      rst_n = 1'b0; t_data = '0; v0 = 0; v1 = 0; clr_err = 0;
      stuck0 = '0; ld_val = '0; ld1 = 0;
      repeat (2) @(negedge clk);
      chk("rst_j", j0, 4'b0000);
      chk("rst_k", k0, 4'b0000);
      chk("rst_done", done0, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", rdy0, 1'b1);
      chk("rst_err", err0, 8'd0);
      chk("rst_mask", mask0, 4'b0000);

      // reset in the middle of DRIVE
      t_data = 4'b1010; v0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v0 = 1'b0;
      chk("mid_drive_j", j0, 4'b1010);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_j", j0, 4'b0000);
      chk("async_rst_k", k0, 4'b0000);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_ready", rdy0, 1'b1);
      chk("rel_err", err0, 8'd0);
      chk("rel_mask", mask0, 4'b0000);
      chk("rel_done", done0, 1'b0);

      // set/reset path
      send(0, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 0, 0);
      chk("bank_q_1010", q0, 4'b1010);
      send(0, 4'b0110, 4'b0100, 4'b1000, 4'b0000, 0, 0);
      chk("bank_q_0110", q0, 4'b0110);

      // toggle path
      @(negedge clk);
      ld_val = 4'b1100; ld1 = 1'b1;
      @(negedge clk);
      ld1 = 1'b0;
      send(1, 4'b0101, 4'b1001, 4'b1001, 4'b0000, 0, 0);
      chk("bank1_q_0101", q1, 4'b0101);

      // bit 2 stuck at 0
      stuck0 = 4'b0100;
      send(0, 4'b0100, 4'b0100, 4'b0010, 4'b0100, 1, 0);
      chk("fault_err1", err0, 8'd1);
      for (int i = 0; i < 259; i++)
         send(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1, 0);
      chk("sat_err", err0, 8'd255);
      send(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1, 1);
      chk("clr_err", err0, 8'd0);

      // back-to-back with T_VALID held high
      stuck0 = '0;
      d0_before = done0_cnt;
      @(negedge clk);
      v0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("b2b_ready", rdy0, 1'b1);
         t_data = bt[i];
         push(0, 4'b0000, 0, 0);
         acc[i] = $time;
         @(posedge clk);
         @(negedge clk);
         chk("b2b_j", j0, bj[i]);
         chk("b2b_k", k0, bk[i]);
         @(posedge clk);
         @(negedge clk);
         chk("b2b_chk_jk", {j0, k0}, 8'h00);
         chk("b2b_chk_rdy", rdy0, 1'b0);
         @(posedge clk);
         @(negedge clk);
      end
      v0 = 1'b0;
      chk("b2b_idle_jk", {j0, k0}, 8'h00);
      chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd30);
      chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd30);
      repeat (3) @(negedge clk);
      chk("b2b_done_cnt", done0_cnt - d0_before, 3);
      chk("b2b_final_q", q0, 4'b0000);
      chk("sb0_empty", sb0.size(), 0);
      chk("sb1_empty", sb1.size(), 0);
      chk("done1_cnt", done1_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
